// File: rtl/ysyx_23060240_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060240_lsu
//  Purpose  : Load/store unit between the EXU and a handshaked data-memory
//             port. One transaction at a time is carried through a
//             registered IDLE -> ISSUE -> WAIT -> RESP sequence. The unit
//             builds byte-lane strobes and lane-shifted store data, and
//             aligns and extends load data. Illegal accesses are answered
//             with an error and never reach the bus.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W       : data path width, 32 or 64
//    ADDR_W       : byte address width (at least 3)
//    MISALIGN_CHK : 1 = misaligned access is an error,
//                   0 = low offset bits are masked and the access is issued
//  Ports
//    clk, rst_n                         clock, asynchronous active-low reset
//    req_valid/req_ready                EXU request handshake
//    req_wen, req_addr, req_wdata,
//    req_size, req_unsigned             request payload
//    rsp_valid/rsp_ready                EXU response handshake
//    rsp_rdata, rsp_err                 response payload
//    mem_req_valid/mem_req_ready        bus request handshake
//    mem_we, mem_addr, mem_wdata,
//    mem_wstrb                          bus request payload
//    mem_rsp_valid, mem_rdata,
//    mem_rsp_err                        bus response
// ============================================================================
module ysyx_23060240_lsu #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int MISALIGN_CHK = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_rsp_err
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = (DATA_W == 64) ? 3 : 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                wen_q, wen_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   // ------------------------------------------------------------------------
   // Request decode: legality, lane offset, strobe and shifted store data
   // ------------------------------------------------------------------------
   logic [7:0]          lane_mask;
   logic [2:0]          align_mask;
   logic                misaligned;
   logic                illegal;
   logic [OFF_W-1:0]    req_off;
   logic [15:0]         strb_wide;
   logic [STRB_W-1:0]   req_strb;
   logic [DATA_W-1:0]   req_lane_data;

   always_comb begin
      case (req_size)
         2'd0:    begin lane_mask = 8'h01; align_mask = 3'b000; end
         2'd1:    begin lane_mask = 8'h03; align_mask = 3'b001; end
         2'd2:    begin lane_mask = 8'h0F; align_mask = 3'b011; end
         default: begin lane_mask = 8'hFF; align_mask = 3'b111; end
      endcase

      misaligned = |(req_addr[2:0] & align_mask);
      illegal    = ((DATA_W == 32) && (req_size == 2'd3)) ||
                   ((MISALIGN_CHK != 0) && misaligned);

      // Without the misalignment check, the access is forced onto its
      // natural boundary inside the data word.
      req_off = req_addr[OFF_W-1:0];
      if (MISALIGN_CHK == 0) begin
         req_off = req_off & ~align_mask[OFF_W-1:0];
      end

      // Shift in a 16-bit vector so an 8-lane mask never overflows before
      // truncation to the real strobe width.
      strb_wide     = {8'h00, lane_mask} << req_off;
      req_strb      = strb_wide[STRB_W-1:0];
      req_lane_data = req_wdata << {req_off, 3'b000};
   end

   // ------------------------------------------------------------------------
   // Load formatting: shift the addressed bytes down, then extend
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0]   shifted;
   logic [63:0]         sh64;
   logic [63:0]         load64;
   logic [DATA_W-1:0]   load_result;

   always_comb begin
      shifted              = mem_rdata >> {off_q, 3'b000};
      sh64                 = '0;
      sh64[DATA_W-1:0]     = shifted;
      // Word on a 32-bit path is extended to 64 and then truncated, so the
      // unsigned flag naturally has no effect there.
      case (size_q)
         2'd0:    load64 = {{56{~uns_q & sh64[7]}},  sh64[7:0]};
         2'd1:    load64 = {{48{~uns_q & sh64[15]}}, sh64[15:0]};
         2'd2:    load64 = {{32{~uns_q & sh64[31]}}, sh64[31:0]};
         default: load64 = sh64;
      endcase
      load_result = load64[DATA_W-1:0];
   end

   // ------------------------------------------------------------------------
   // FSM next state and registered datapath
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      wen_d       = wen_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wen_d  = req_wen;
               size_d = req_size;
               uns_d  = req_unsigned;
               off_d  = req_off;
               if (illegal) begin
                  // Answered directly; bus outputs keep their old values
                  // because mem_req_valid is never raised.
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = RESP;
               end else begin
                  mem_we_d    = req_wen;
                  mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  mem_wdata_d = req_lane_data;
                  mem_wstrb_d = req_wen ? req_strb : '0;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = '0;
                  state_d     = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (mem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               rsp_err_d   = mem_rsp_err;
               rsp_rdata_d = (mem_rsp_err || wen_q) ? '0 : load_result;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wen_q       <= 1'b0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         off_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign req_ready     = (state_q == IDLE);
   assign mem_req_valid = (state_q == ISSUE);
   assign rsp_valid     = (state_q == RESP);
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wstrb     = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060240_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060240_lsu
//  Purpose  : Self-checking bench for ysyx_23060240_lsu. Instance A is a
//             32-bit unit with misalignment checking, instance B a 64-bit
//             unit with offset masking. A byte-level reference model gives
//             the expected bus request and response for every transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060240_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;            // 0 = instance A (32-bit), 1 = instance B (64-bit)
   logic        req_valid;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        rsp_ready;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [63:0] mem_rdata;
   logic        mem_rsp_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   logic        a_req_valid, b_req_valid;
   assign a_req_valid = req_valid & ~sel;
   assign b_req_valid = req_valid &  sel;

   logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_req_valid, a_mem_we;
   logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_wstrb;
   logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_req_valid, b_mem_we;
   logic [63:0] b_rsp_rdata, b_mem_wdata;
   logic [31:0] b_mem_addr;
   logic [7:0]  b_mem_wstrb;

   ysyx_23060240_lsu #(.DATA_W(32), .ADDR_W(32), .MISALIGN_CHK(1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata),
      .rsp_err(a_rsp_err),
      .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_wstrb(a_mem_wstrb), .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata(mem_rdata[31:0]), .mem_rsp_err(mem_rsp_err)
   );

   ysyx_23060240_lsu #(.DATA_W(64), .ADDR_W(32), .MISALIGN_CHK(0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_err(b_rsp_err),
      .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_wstrb(b_mem_wstrb), .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
   );

   // Selected instance outputs, zero-extended to the 64-bit view
   logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_req_valid, o_mem_we;
   logic [63:0] o_rsp_rdata, o_mem_wdata;
   logic [31:0] o_mem_addr;
   logic [7:0]  o_mem_wstrb;

   always_comb begin
      o_req_ready     = sel ? b_req_ready     : a_req_ready;
      o_rsp_valid     = sel ? b_rsp_valid     : a_rsp_valid;
      o_rsp_err       = sel ? b_rsp_err       : a_rsp_err;
      o_mem_req_valid = sel ? b_mem_req_valid : a_mem_req_valid;
      o_mem_we        = sel ? b_mem_we        : a_mem_we;
      o_rsp_rdata     = sel ? b_rsp_rdata     : {32'h0, a_rsp_rdata};
      o_mem_wdata     = sel ? b_mem_wdata     : {32'h0, a_mem_wdata};
      o_mem_addr      = sel ? b_mem_addr      : a_mem_addr;
      o_mem_wstrb     = sel ? b_mem_wstrb     : {4'h0, a_mem_wstrb};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-level reference: which bytes of the data word are touched and
   // where each request/response byte lands.
   task automatic model(input bit s, input bit wen, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input bit berr,
                        output bit ill, output logic [31:0] maddr,
                        output logic [7:0] strb, output logic [63:0] mwdata,
                        output logic [63:0] rres, output bit rerr);
      int  w  = s ? 8 : 4;
      int  nb = 1 << size;
      int  off;
      bit  neg;
      ill   = (size == 2'd3 && w == 4) || (!s && (addr % nb) != 0);
      off   = addr % w;
      if (s) off = off - (off % nb);
      maddr = addr - (addr % w);
      strb = '0; mwdata = '0; rres = '0;
      for (int i = 0; i < w; i++) begin
         if (wen && i >= off && i < off + nb) strb[i] = 1'b1;
         if (i >= off) mwdata[8*i +: 8] = wdata[8*(i-off) +: 8];
      end
      neg = !uns && rdata[8*(off+nb)-1];
      for (int i = 0; i < w; i++) begin
         if (i < nb) rres[8*i +: 8] = rdata[8*(off+i) +: 8];
         else        rres[8*i +: 8] = neg ? 8'hFF : 8'h00;
      end
      rerr = ill || berr;
      if (rerr || wen) rres = '0;
   endtask

   // One complete transaction driven and checked cycle by cycle, starting
   // and ending at a falling edge with the selected instance idle.
   task automatic txn(input bit s, input bit wen, input logic [31:0] addr,
                      input logic [1:0] size, input bit uns,
                      input logic [63:0] wdata, input logic [63:0] rdata,
                      input bit berr, input int req_stall, input int rsp_dly,
                      input int rsp_stall,
                      output logic [63:0] got_rdata, output bit got_err,
                      output logic [7:0] got_strb);
      bit          ill, rerr;
      logic [31:0] maddr;
      logic [7:0]  strb;
      logic [63:0] mwdata, rres;
      model(s, wen, addr, size, uns, wdata, rdata, berr, ill, maddr, strb, mwdata, rres, rerr);
      sel = s;
      #1;
      chk("idle_req_ready", o_req_ready, 1);
      req_wen = wen; req_addr = addr; req_size = size; req_unsigned = uns;
      req_wdata = wdata; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = {$urandom, $urandom};
      got_strb  = '0;
      if (!ill) begin
         got_strb = o_mem_wstrb;
         for (int k = 0; k <= req_stall; k++) begin
            chk("issue_valid", o_mem_req_valid, 1);
            chk("issue_req_ready", o_req_ready, 0);
            chk("issue_addr", o_mem_addr, maddr);
            chk("issue_we", o_mem_we, wen);
            chk("issue_strb", o_mem_wstrb, strb);
            if (wen) chk("issue_wdata", o_mem_wdata, mwdata);
            mem_req_ready = (k == req_stall);
            @(negedge clk);
         end
         mem_req_ready = 1'b0;
         for (int k = 0; k <= rsp_dly; k++) begin
            chk("wait_no_req", o_mem_req_valid, 0);
            chk("wait_no_rsp", o_rsp_valid, 0);
            mem_rsp_valid = (k == rsp_dly);
            mem_rdata     = (k == rsp_dly) ? rdata : {$urandom, $urandom};
            mem_rsp_err   = (k == rsp_dly) ? berr : 1'b1;
            @(negedge clk);
         end
         mem_rsp_valid = 1'b0;
         mem_rdata     = {$urandom, $urandom};
         mem_rsp_err   = 1'b0;
      end else begin
         chk("illegal_no_req", o_mem_req_valid, 0);
      end
      got_rdata = o_rsp_rdata;
      got_err   = o_rsp_err;
      for (int k = 0; k <= rsp_stall; k++) begin
         chk("resp_valid", o_rsp_valid, 1);
         chk("resp_rdata", o_rsp_rdata, rres);
         chk("resp_err", o_rsp_err, rerr);
         chk("resp_req_ready", o_req_ready, 0);
         chk("resp_no_req", o_mem_req_valid, 0);
         rsp_ready = (k == rsp_stall);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      chk("after_rsp_valid", o_rsp_valid, 0);
   endtask

   task automatic chk_rst();
      chk("rst_a_ctl", {a_req_ready, a_rsp_valid, a_mem_req_valid, a_mem_we, a_rsp_err}, 64'b10000);
      chk("rst_a_dat", {a_rsp_rdata, a_mem_addr}, 64'h0);
      chk("rst_a_wr",  {a_mem_wdata, a_mem_wstrb}, 64'h0);
      chk("rst_b_ctl", {b_req_ready, b_rsp_valid, b_mem_req_valid, b_mem_we, b_rsp_err}, 64'b10000);
      chk("rst_b_rdata", b_rsp_rdata, 64'h0);
      chk("rst_b_wdata", b_mem_wdata, 64'h0);
      chk("rst_b_addr", {b_mem_addr, b_mem_wstrb}, 64'h0);
   endtask

   logic [63:0] g_rd;
   bit          g_err;
   logic [7:0]  g_strb;

   initial begin
      rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
      req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
      rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rdata = '0; mem_rsp_err = 1'b0;
      repeat (2) @(negedge clk);
      chk_rst();
      rst_n = 1'b1;
      @(negedge clk);

      // lw, zero-wait bus
      txn(0, 0, 32'h80000004, 2'd2, 0, 64'h0, 64'hDEADBEEF, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("lw_rdata", g_rd, 64'hDEADBEEF);
      chk("lw_err", g_err, 0);
      // lb / lbu at the top byte
      txn(0, 0, 32'h80000003, 2'd0, 0, 64'h0, 64'h85112233, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("lb_rdata", g_rd, 64'hFFFFFF85);
      txn(0, 0, 32'h80000003, 2'd0, 1, 64'h0, 64'h85112233, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("lbu_rdata", g_rd, 64'h00000085);
      // sh into the upper half
      txn(0, 1, 32'h80000002, 2'd1, 0, 64'h0000ABCD, 64'h0, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("sh_strb", g_strb, 8'h0C);
      chk("sh_rdata", g_rd, 64'h0);
      // misaligned lw
      txn(0, 0, 32'h80000002, 2'd2, 0, 64'h0, 64'h12345678, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("mis_err", g_err, 1);
      chk("mis_rdata", g_rd, 64'h0);
      // ld on the 32-bit path is illegal
      txn(0, 0, 32'h80000008, 2'd3, 0, 64'h0, 64'h12345678, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("ld32_err", g_err, 1);
      // back-pressure on both handshakes
      txn(0, 0, 32'h80000008, 2'd2, 0, 64'h0, 64'hCAFEF00D, 0, 3, 1, 2, g_rd, g_err, g_strb);
      chk("bp_rdata", g_rd, 64'hCAFEF00D);
      // 64-bit: faulting ld, masked lw, plain ld
      txn(1, 0, 32'h80000008, 2'd3, 0, 64'h0, 64'h1122334455667788, 1, 0, 0, 0, g_rd, g_err, g_strb);
      chk("ld_berr_err", g_err, 1);
      chk("ld_berr_rdata", g_rd, 64'h0);
      txn(1, 0, 32'h80000006, 2'd2, 0, 64'h0, 64'h8899AABB11223344, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("lw64_mask_rdata", g_rd, 64'hFFFFFFFF8899AABB);
      txn(1, 0, 32'h80000010, 2'd3, 1, 64'h0, 64'hF0E1D2C3B4A59687, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("ld64_rdata", g_rd, 64'hF0E1D2C3B4A59687);
      txn(1, 1, 32'h80000005, 2'd1, 0, 64'h0000000000001234, 64'h0, 0, 0, 0, 0, g_rd, g_err, g_strb);
      chk("sh64_mask_strb", g_strb, 8'h30);

      // randomized transactions on both instances
      for (int n = 0; n < 60; n++) begin
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'h80000000 | ($urandom & 32'hFF), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
             ($urandom_range(0, 7) == 0), $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2), g_rd, g_err, g_strb);
      end

      // reset while waiting for the bus response
      sel = 1'b1;
      req_wen = 1'b0; req_addr = 32'h80000010; req_size = 2'd3; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstw_issue", b_mem_req_valid, 1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("rstw_in_wait", {b_mem_req_valid, b_rsp_valid, b_req_ready}, 64'b000);
      rst_n = 1'b0;
      #1;
      chk_rst();
      @(negedge clk);
      chk_rst();
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1; mem_rdata = 64'h0123456789ABCDEF; mem_rsp_err = 1'b0;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("stale_rsp_b", {b_rsp_valid, b_req_ready}, 64'b01);
      chk("stale_rsp_a", {a_rsp_valid, a_req_ready}, 64'b01);
      @(negedge clk);
      chk("stale_rsp_b2", b_rsp_valid, 0);
      chk("stale_rdata_b", b_rsp_rdata, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
